seg_display_reader: RTL and testbench
=====================================

# seg_display_reader

Passive monitor for the multiplexed 4-digit 7-segment display bus. It samples the segment and digit-select lines driven by the display scan logic, debounces each digit dwell, and decodes the segment pattern back to BCD. It publishes a full 4-digit frame once every digit has been seen. It sits beside the display driver in the calculator top and feeds on-board self-test and bench loopback checks.

## Interface
Parameters:
- STABLE_CYCLES, 4: consecutive identical registered samples required before a digit is captured (≥2).
- TIMEOUT_CYCLES, 4096: cycles without a completed frame before `stale` asserts.

Ports:
- clk  in  1  system clock; the only clock (same clock as the display scan logic).
- reset  in  1  synchronous, active-high; one clock, synchronous reset.
- seg  in  8  segment lines, active-high; bit0=a … bit6=g, bit7=DP.
- sel  in  4  digit select, one-hot active-high; bit0 = DS1 (least-significant digit) … bit3 = DS4.
- value  out  16  captured BCD frame; nibble i holds digit i.
- dp  out  4  captured decimal-point bit for each digit.
- err  out  4  per-digit flag: segment pattern was not a legal code.
- frame_valid  out  1  one-cycle pulse: `value`, `dp` and `err` were just updated.
- stale  out  1  high when no frame has completed for TIMEOUT_CYCLES cycles.

## Operation
- Input stage: `seg` and `sel` are registered every cycle into `s_seg` and `s_sel`. All other logic uses only the registered copies.
- Stability counter: increments, saturating, while {s_seg, s_sel} equals the previous cycle's value and `s_sel` is one-hot. Any change, or a non-one-hot `s_sel` (zero or multiple bits set), clears it and re-arms capture.
- Capture: when the counter reaches STABLE_CYCLES-1 and the dwell is armed, the reader captures exactly one digit per dwell, then disarms:
  - index = position of the set bit in `s_sel`;
  - decoded nibble goes to the shadow digit register, `s_seg[7]` to the shadow DP register;
  - the decode-failure bit goes to the shadow error register;
  - the `seen[index]` bit is set.
- Decode: seg[6:0] patterns for 0–9 map to 0x0–0x9. The all-off pattern (blank) maps to 0xA, `err`=0. Any other pattern maps to 0xF, `err`=1.
- Re-capture of a digit before the frame completes overwrites that digit's shadow entry. `seen` is not affected.
- Frame completion: on the cycle after `seen` becomes 4'b1111:
  - shadow registers copy to `value`/`dp`/`err`;
  - `frame_valid` pulses for 1 cycle;
  - `seen` clears;
  - the timeout counter clears.
- Timeout: counter increments every cycle and saturates at TIMEOUT_CYCLES. `stale` = (counter == TIMEOUT_CYCLES). `stale` is cleared by `frame_valid`.
- State: IDLE (counter cleared, armed) → SETTLING (counting) → CAPTURED (disarmed, waiting for a change) → SETTLING on the next change.

## Timing
- Reset values: `value`=0, `dp`=0, `err`=0, `frame_valid`=0, `stale`=0. All internal registers and counters are 0, and capture is armed.
- Reset takes priority over every other event, including a capture or frame completion in the same cycle.
- Capture latency: inputs held constant from edge N are written to the shadow registers at edge N+STABLE_CYCLES (1 register stage plus STABLE_CYCLES-1 counts).
- Frame latency: `frame_valid` is high in the cycle after the 4th distinct digit capture. `value` is valid in that same cycle and holds until the next frame.
- A dwell shorter than STABLE_CYCLES registered samples is never captured.
- A select change and a capture can occur in the same cycle. The capture uses the pre-change registered sample, and the counter clears on the following cycle.
- Frame completion and `stale` saturation can occur in the same cycle. `frame_valid` wins, and `stale` is 0 in the next cycle.
- Reset mid-frame discards partial `seen`/shadow contents.

## Structure
- Shared package (with the existing BCD-to-segment encoder):
  - `SEG_0`…`SEG_9` and `SEG_BLANK` 7-bit constants;
  - `BCD_BLANK`=4'hA and `BCD_ERR`=4'hF.
- Encoder and reader must use the same constants.
- One sub-module: `seg_2bcd`, a combinational decoder with inputs seg[6:0] and outputs {nibble, err}. The stability/capture/frame logic stays in `seg_display_reader`.

## Test plan
- Reset, then scan digits 1,2,3,4 (DS1→DS4) with 8-cycle dwells, STABLE_CYCLES=4 → single `frame_valid` with `value`=0x4321, `dp`=0, `err`=0.
- Same scan with DP set on DS2 and pattern 7'b1010101 on DS3 → `value`=0x4F21, `dp`=4'b0010, `err`=4'b0100.
- DS1 dwell of 3 cycles, others 8 → no capture of DS1 and no `frame_valid`. On the next full scan, a frame is produced with the new DS1 value.
- `sel`=4'b0011 held 20 cycles, then a normal scan of 5,6,7,8 → nothing captured during the illegal select, then `value`=0x8765.
- TIMEOUT_CYCLES=64, no scan for 70 cycles → `stale`=1 from cycle 64. A subsequent full scan gives `frame_valid`, then `stale`=0.
- Assert `reset` after 3 digits captured, then scan 9,9,9,9 → outputs 0 during reset, then `value`=0x9999 with no leftover digits.

Source files
------------

// File: rtl/seg_display_reader_pkg.sv
// Shared constants for the 7-segment display path. The BCD-to-segment
// encoder and the display reader both take their segment codes from here,
// so the two ends of the bus always agree on the patterns.
package seg_display_reader_pkg;

    // Segment patterns, bit0 = a ... bit6 = g, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Non-decimal nibble codes
    localparam logic [3:0] BCD_BLANK = 4'hA;
    localparam logic [3:0] BCD_ERR   = 4'hF;

    // Dwell tracking states of the reader
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,   // counter cleared, capture armed
        ST_SETTLING = 2'd1,   // counting identical samples
        ST_CAPTURED = 2'd2    // digit taken, waiting for the dwell to end
    } rd_state_t;

    // Encoder side: BCD nibble to segment pattern (blank for anything else)
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // True when exactly one bit of a 4-bit select is set
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'h0) && ((v & (v - 4'h1)) == 4'h0);
    endfunction

    // Position of the set bit in a one-hot 4-bit select
    function automatic logic [1:0] onehot4_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg_display_reader_seg_2bcd.sv
// Combinational segment-pattern to BCD decoder. Digits 0-9 decode to their
// value, the all-off pattern decodes to the blank code, and anything else
// decodes to the error code with err raised.
module seg_2bcd
    import seg_display_reader_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       err
);

    // Pattern lookup; only the blank pattern is a legal non-digit
    always_comb begin
        nibble = BCD_ERR;
        err    = 1'b1;
        case (seg)
            SEG_0:     begin nibble = 4'd0;      err = 1'b0; end
            SEG_1:     begin nibble = 4'd1;      err = 1'b0; end
            SEG_2:     begin nibble = 4'd2;      err = 1'b0; end
            SEG_3:     begin nibble = 4'd3;      err = 1'b0; end
            SEG_4:     begin nibble = 4'd4;      err = 1'b0; end
            SEG_5:     begin nibble = 4'd5;      err = 1'b0; end
            SEG_6:     begin nibble = 4'd6;      err = 1'b0; end
            SEG_7:     begin nibble = 4'd7;      err = 1'b0; end
            SEG_8:     begin nibble = 4'd8;      err = 1'b0; end
            SEG_9:     begin nibble = 4'd9;      err = 1'b0; end
            SEG_BLANK: begin nibble = BCD_BLANK; err = 1'b0; end
            default:   begin nibble = BCD_ERR;   err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg_display_reader.sv
// Passive monitor for the multiplexed 4-digit 7-segment bus. Registers the
// bus, waits for each digit dwell to settle, decodes it back to BCD into a
// shadow frame, and publishes the frame once all four digits have been seen.
module seg_display_reader
    import seg_display_reader_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  seg,
    input  logic [3:0]  sel,
    output logic [15:0] value,
    output logic [3:0]  dp,
    output logic [3:0]  err,
    output logic        frame_valid,
    output logic        stale
);

    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] CAP_CNT = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    logic [7:0]    r_s_seg;
    logic [3:0]    r_s_sel;
    logic [7:0]    r_prev_seg;
    logic [3:0]    r_prev_sel;
    logic [SW-1:0] r_stab_cnt;
    rd_state_t     r_state;
    logic [3:0]    r_shadow_digit [4];
    logic [3:0]    r_shadow_dp;
    logic [3:0]    r_shadow_err;
    logic [3:0]    r_seen;
    logic [TW-1:0] r_tmo_cnt;
    logic [15:0]   r_value;
    logic [3:0]    r_dp;
    logic [3:0]    r_err;
    logic          r_frame_valid;

    logic          w_stable;
    logic [SW-1:0] w_cnt_inc;
    logic          w_capture;
    logic [1:0]    w_idx;
    logic [3:0]    w_cap_mask;
    logic          w_complete;
    logic [3:0]    w_dec_nibble;
    logic          w_dec_err;
    logic [15:0]   w_shadow_value;

    // Register the raw bus and keep the previous registered sample for comparison
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_seg    <= 8'h00;
            r_s_sel    <= 4'h0;
            r_prev_seg <= 8'h00;
            r_prev_sel <= 4'h0;
        end else begin
            r_s_seg    <= seg;
            r_s_sel    <= sel;
            r_prev_seg <= r_s_seg;
            r_prev_sel <= r_s_sel;
        end
    end

    // A sample only counts toward a dwell if it repeats and selects exactly one digit
    assign w_stable  = (r_s_seg == r_prev_seg) && (r_s_sel == r_prev_sel) && is_onehot4(r_s_sel);
    assign w_cnt_inc = (r_stab_cnt == CAP_CNT) ? CAP_CNT : r_stab_cnt + 1'b1;
    // Capture on the edge where the count reaches its target, once per dwell
    assign w_capture = w_stable && (r_state != ST_CAPTURED) && (w_cnt_inc == CAP_CNT);
    assign w_idx     = onehot4_index(r_s_sel);
    assign w_cap_mask = 4'b0001 << w_idx;

    seg_2bcd u_seg_2bcd (
        .seg    (r_s_seg[6:0]),
        .nibble (w_dec_nibble),
        .err    (w_dec_err)
    );

    // Dwell FSM: count identical samples, disarm after a capture, re-arm on any change
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_stab_cnt <= '0;
        end else if (!w_stable) begin
            r_state    <= ST_IDLE;
            r_stab_cnt <= '0;
        end else begin
            r_stab_cnt <= w_cnt_inc;
            if (w_capture) begin
                r_state <= ST_CAPTURED;
            end else if (r_state == ST_IDLE) begin
                r_state <= ST_SETTLING;
            end
        end
    end

    // Per-digit shadow entries; a later capture of the same digit overwrites it
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        always_ff @(posedge clk) begin
            if (reset) begin
                r_shadow_digit[gi] <= 4'h0;
                r_shadow_dp[gi]    <= 1'b0;
                r_shadow_err[gi]   <= 1'b0;
            end else if (w_capture && (w_idx == 2'(gi))) begin
                r_shadow_digit[gi] <= w_dec_nibble;
                r_shadow_dp[gi]    <= r_s_seg[7];
                r_shadow_err[gi]   <= w_dec_err;
            end
        end
        assign w_shadow_value[gi*4 +: 4] = r_shadow_digit[gi];
    end

    assign w_complete = (r_seen == 4'hF);

    // Frame publication, seen tracking and the stale timeout counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seen        <= 4'h0;
            r_value       <= 16'h0000;
            r_dp          <= 4'h0;
            r_err         <= 4'h0;
            r_frame_valid <= 1'b0;
            r_tmo_cnt     <= '0;
        end else begin
            r_frame_valid <= w_complete;
            r_seen        <= (w_complete ? 4'h0 : r_seen) | (w_capture ? w_cap_mask : 4'h0);
            if (w_complete) begin
                r_value   <= w_shadow_value;
                r_dp      <= r_shadow_dp;
                r_err     <= r_shadow_err;
                r_tmo_cnt <= '0;
            end else if (r_tmo_cnt != TMO_MAX) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

    assign value       = r_value;
    assign dp          = r_dp;
    assign err         = r_err;
    assign frame_valid = r_frame_valid;
    assign stale       = (r_tmo_cnt == TMO_MAX);

endmodule

// File: tb/tb_seg_display_reader.sv
// Bench for seg_display_reader: directed scans from the test plan plus a
// randomized phase, all checked every cycle against a dwell-history model.
module tb_seg_display_reader;

    localparam int STABLE = 4;
    localparam int TMO    = 64;
    localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  seg;
    logic [3:0]  sel;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  err;
    logic        frame_valid;
    logic        stale;

    int checks   = 0;
    int failures = 0;

    seg_display_reader #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seg         (seg),
        .sel         (sel),
        .value       (value),
        .dp          (dp),
        .err         (err),
        .frame_valid (frame_valid),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [11:0] hist [$];          // registered {seg, sel} samples, newest last
    logic        m_ready = 1'b0;
    logic [3:0]  m_sh_dig [4];
    logic [3:0]  m_sh_dp, m_sh_err, m_seen;
    logic [15:0] m_value;
    logic [3:0]  m_dp, m_err;
    logic        m_fv, m_stale;
    int          m_tcnt;
    int          m_frames = 0;

    function automatic void model_decode(input logic [6:0] p, output logic [3:0] n, output logic e);
        n = 4'hF;
        e = 1'b1;
        if (p == 7'h00) begin
            n = 4'hA;
            e = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            if (PAT[i] == p) begin
                n = 4'(i);
                e = 1'b0;
            end
        end
    endfunction

    task automatic model_step();
        int          n;
        logic        same, fresh;
        logic [3:0]  s_sel, nib;
        logic        e;
        int          idx;
        if (reset) begin
            hist.delete();
            hist.push_back(12'h000);
            for (int i = 0; i < 4; i++) m_sh_dig[i] = 4'h0;
            m_sh_dp = 0; m_sh_err = 0; m_seen = 0;
            m_value = 0; m_dp = 0; m_err = 0; m_fv = 0; m_tcnt = 0;
            m_ready = 1'b1;
        end else if (m_ready) begin
            m_fv = (m_seen == 4'hF);
            if (m_fv) begin
                m_value = {m_sh_dig[3], m_sh_dig[2], m_sh_dig[1], m_sh_dig[0]};
                m_dp    = m_sh_dp;
                m_err   = m_sh_err;
                m_seen  = 4'h0;
                m_tcnt  = 0;
                m_frames++;
            end else if (m_tcnt < TMO) begin
                m_tcnt++;
            end
            // A digit is taken when the newest STABLE samples are identical,
            // select one digit, and the sample before them was different.
            n = hist.size();
            if (n >= STABLE) begin
                same = 1'b1;
                for (int k = 1; k < STABLE; k++)
                    if (hist[n-1-k] != hist[n-1]) same = 1'b0;
                fresh = (n == STABLE) || (hist[n-1-STABLE] != hist[n-1]);
                s_sel = hist[n-1][3:0];
                if (same && fresh && ($countones(s_sel) == 1)) begin
                    idx = 0;
                    for (int i = 0; i < 4; i++) if (s_sel[i]) idx = i;
                    model_decode(hist[n-1][10:4], nib, e);
                    m_sh_dig[idx] = nib;
                    m_sh_dp[idx]  = hist[n-1][11];
                    m_sh_err[idx] = e;
                    m_seen[idx]   = 1'b1;
                end
            end
            hist.push_back({seg, sel});
            if (hist.size() > STABLE + 1) void'(hist.pop_front());
        end
        m_stale = (m_tcnt == TMO);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    int          dut_frames = 0;
    logic [15:0] last_val = 16'h0;
    logic [3:0]  last_dp = 4'h0, last_err = 4'h0;

    initial begin
        forever begin
            @(negedge clk);
            if (m_ready) begin
                checks++;
                if (value !== m_value || dp !== m_dp || err !== m_err ||
                    frame_valid !== m_fv || stale !== m_stale) begin
                    failures++;
                    $display("FAIL cycle t=%0t actual value=%h dp=%b err=%b fv=%b stale=%b required value=%h dp=%b err=%b fv=%b stale=%b",
                             $time, value, dp, err, frame_valid, stale,
                             m_value, m_dp, m_err, m_fv, m_stale);
                end
                if (frame_valid === 1'b1) begin
                    dut_frames++;
                    last_val = value;
                    last_dp  = dp;
                    last_err = err;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dig(input int d, input logic dpb);
        return {dpb, PAT[d]};
    endfunction

    task automatic idle(input int n);
        sel = 4'h0;
        seg = 8'h00;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic scan(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                        input logic [7:0] p3, input int w0, input int w);
        sel = 4'b0001; seg = p0; repeat (w0) @(negedge clk);
        sel = 4'b0010; seg = p1; repeat (w) @(negedge clk);
        sel = 4'b0100; seg = p2; repeat (w) @(negedge clk);
        sel = 4'b1000; seg = p3; repeat (w) @(negedge clk);
    endtask

    task automatic chk_frame(input string name, input int f0, input int nexp,
                             input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        #1;
        chk({name, "_count"}, dut_frames - f0, nexp);
        chk({name, "_value"}, last_val, v);
        chk({name, "_dp"}, last_dp, d);
        chk({name, "_err"}, last_err, e);
        chk({name, "_model"}, m_value, v);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int f0;
        reset = 1'b1;
        seg   = 8'h00;
        sel   = 4'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_value", value, 16'h0);
        chk("rst_dp", dp, 4'h0);
        chk("rst_err", err, 4'h0);
        chk("rst_fv", frame_valid, 1'b0);
        chk("rst_stale", stale, 1'b0);
        reset = 1'b0;

        // Plain scan 1,2,3,4
        f0 = dut_frames;
        scan(dig(1, 0), dig(2, 0), dig(3, 0), dig(4, 0), 8, 8);
        idle(4);
        chk_frame("scan1234", f0, 1, 16'h4321, 4'b0000, 4'b0000);

        // DP on DS2, illegal pattern on DS3
        f0 = dut_frames;
        scan(dig(1, 0), dig(2, 1), 8'h55, dig(4, 0), 8, 8);
        idle(4);
        chk_frame("dp_err", f0, 1, 16'h4F21, 4'b0010, 4'b0100);

        // Minimum dwells: select change coincides with each capture; blank on DS2
        f0 = dut_frames;
        scan(dig(0, 0), 8'h00, dig(9, 0), dig(8, 0), 4, 4);
        idle(4);
        chk_frame("min_dwell", f0, 1, 16'h89A0, 4'b0000, 4'b0000);

        // Short DS1 dwell is ignored, next scan supplies DS1 and completes
        f0 = dut_frames;
        scan(dig(7, 0), dig(2, 0), dig(3, 0), dig(4, 0), 3, 8);
        idle(4);
        #1 chk("short_dwell_nofr", dut_frames - f0, 0);
        scan(dig(5, 0), dig(2, 0), dig(3, 0), dig(4, 0), 8, 8);
        idle(4);
        chk_frame("short_dwell", f0, 1, 16'h4325, 4'b0000, 4'b0000);

        // Illegal two-hot select held, then a clean scan
        do_reset(2);
        f0 = dut_frames;
        sel = 4'b0011; seg = dig(9, 0);
        repeat (20) @(negedge clk);
        #1 chk("twohot_nofr", dut_frames - f0, 0);
        scan(dig(5, 0), dig(6, 0), dig(7, 0), dig(8, 0), 8, 8);
        idle(4);
        chk_frame("twohot", f0, 1, 16'h8765, 4'b0000, 4'b0000);

        // Timeout: stale rises exactly TMO cycles after the last reset
        reset = 1'b1; sel = 4'h0; seg = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (TMO - 1) @(negedge clk);
        #1 chk("stale_before", stale, 1'b0);
        @(negedge clk);
        #1 chk("stale_at", stale, 1'b1);
        repeat (6) @(negedge clk);
        f0 = dut_frames;
        scan(dig(1, 0), dig(2, 0), dig(3, 0), dig(4, 0), 8, 8);
        idle(2);
        chk_frame("stale_scan", f0, 1, 16'h4321, 4'b0000, 4'b0000);
        chk("stale_cleared", stale, 1'b0);

        // Reset mid-frame discards the partial frame
        sel = 4'b0001; seg = dig(1, 0); repeat (8) @(negedge clk);
        sel = 4'b0010; seg = dig(2, 0); repeat (8) @(negedge clk);
        sel = 4'b0100; seg = dig(3, 0); repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_value", value, 16'h0);
        chk("midrst_fv", frame_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        f0 = dut_frames;
        scan(dig(9, 0), dig(9, 0), dig(9, 0), dig(9, 0), 8, 8);
        idle(4);
        chk_frame("after_rst", f0, 1, 16'h9999, 4'b0000, 4'b0000);

        // Randomized dwells, occasional illegal selects, patterns and resets
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 9) < 8) sel = 4'b0001 << $urandom_range(0, 3);
            else                          sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) seg = dig($urandom_range(0, 9), 1'($urandom_range(0, 1)));
            else                           seg = 8'($urandom_range(0, 255));
            reset = ($urandom_range(0, 29) == 0);
            repeat ($urandom_range(1, 10)) @(negedge clk);
            reset = 1'b0;
        end
        idle(6);
        #1;
        chk("rand_frames", dut_frames, m_frames);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
